// File: rtl/ahb_apb_bridge_gen2_if.sv
// AHB slave-side and APB requester-side signals of the AHB-to-APB bridge.
// The bridge connects through the slave modport; the environment driving
// the AHB master and the APB completers uses the master modport.
interface ahb_apb_bridge_gen2_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3
);
  logic [ADDR_W-1:0]     Haddr;
  logic [1:0]            Htrans;
  logic                  Hwrite;
  logic [DATA_W-1:0]     Hwdata;
  logic                  Hreadyin;
  logic                  Hreadyout;
  logic [1:0]            Hresp;
  logic [DATA_W-1:0]     Hrdata;
  logic [ADDR_W-1:0]     Paddr;
  logic [NUM_SLAVES-1:0] Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [DATA_W-1:0]     Pwdata;
  logic [DATA_W-1:0]     Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport slave (
    input  Haddr, Htrans, Hwrite, Hwdata, Hreadyin, Prdata, Pready, Pslverr,
    output Hreadyout, Hresp, Hrdata, Paddr, Pselx, Penable, Pwrite, Pwdata
  );

  modport master (
    output Haddr, Htrans, Hwrite, Hwdata, Hreadyin, Prdata, Pready, Pslverr,
    input  Hreadyout, Hresp, Hrdata, Paddr, Pselx, Penable, Pwrite, Pwdata
  );
endinterface

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-to-APB bridge: one AHB slave port fanned out to NUM_SLAVES APB
// completers laid out back to back from BASE_ADDR, SLAVE_SPAN bytes each.
// One APB transfer in flight at a time; supports Pready wait states,
// Pslverr-to-ERROR and out-of-map decode errors.
// Optional feature macro: BRIDGE_TIMEOUT_EN (abort ACCESS after
// TIMEOUT_CYCLES unready cycles with an ERROR response).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; ready, OKAY, P-signals inactive
// LATCH  | AHB data phase of an accepted transfer; capture Hwdata
// SETUP  | APB setup phase, Pselx asserted
// ACCESS | APB access phase, Penable asserted, waiting on Pready
// ERR1   | first ERROR cycle (not ready)
// ERR2   | second ERROR cycle (ready); may accept the next transfer
module ahb_apb_bridge_gen2 #(
  parameter int              NUM_SLAVES     = 3,
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLAVE_SPAN   = 32'h0400_0000,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input logic                  Hclk,
  input logic                  Hresetn,
  ahb_apb_bridge_gen2_if.slave bus
);

  localparam int EXT_W   = ADDR_W + 5;
  localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int SPAN_SH = $clog2(SLAVE_SPAN);
  localparam logic [EXT_W-1:0] WIN_LO = EXT_W'(BASE_ADDR);
  localparam logic [EXT_W-1:0] WIN_HI = WIN_LO + EXT_W'(NUM_SLAVES) * EXT_W'(SLAVE_SPAN);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     paddr_q;
  logic                  pwrite_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic                  penable_q;
  logic [IDX_W-1:0]      idx_q;

  logic                  in_range;
  logic [ADDR_W-1:0]     offset;
  logic [IDX_W-1:0]      idx_d;
  logic [NUM_SLAVES-1:0] psel_dec;
  logic                  slot;
  logic                  accept;
  logic                  hready;
  logic [1:0]            hresp;
  logic [DATA_W-1:0]     hrdata;
  logic                  timeout_hit;

  assign in_range = (EXT_W'(bus.Haddr) >= WIN_LO) && (EXT_W'(bus.Haddr) < WIN_HI);
  assign offset   = bus.Haddr - BASE_ADDR;
  assign idx_d    = IDX_W'(offset >> SPAN_SH);

  // One-hot completer select from the captured index
  always_comb begin
    psel_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_dec[i] = (idx_q == IDX_W'(i));
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] to_cnt_q;

  // Count unready ACCESS cycles; restart in every SETUP
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      to_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !bus.Pready) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_ACCESS) && !bus.Pready &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Never times out: ACCESS waits on Pready indefinitely
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and combinational AHB response
  always_comb begin
    state_d = state_q;
    hready  = 1'b1;
    hresp   = RESP_OKAY;
    hrdata  = '0;
    slot    = 1'b0;
    case (state_q)
      S_IDLE: slot = 1'b1;
      S_LATCH: begin
        hready  = 1'b0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        hready  = 1'b0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!bus.Pready) begin
          hready = 1'b0;
          if (timeout_hit) state_d = S_ERR1;
        end else if (bus.Pslverr) begin
          hready  = 1'b0;
          hresp   = RESP_ERROR;
          state_d = S_ERR2;
        end else begin
          slot = 1'b1;
          if (!pwrite_q) hrdata = bus.Prdata;
        end
      end
      S_ERR1: begin
        hready  = 1'b0;
        hresp   = RESP_ERROR;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        hresp = RESP_ERROR;
        slot  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    accept = slot && hready && bus.Hreadyin && bus.Htrans[1];
    if (slot) begin
      if (accept) state_d = in_range ? S_LATCH : S_ERR1;
      else        state_d = S_IDLE;
    end
  end

  // State register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Registered APB outputs; select/enable follow the state being entered
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (accept && in_range) begin
        paddr_q  <= bus.Haddr;
        pwrite_q <= bus.Hwrite;
        idx_q    <= idx_d;
      end
      if (state_q == S_LATCH && pwrite_q) pwdata_q <= bus.Hwdata;
      psel_q    <= (state_d == S_SETUP || state_d == S_ACCESS) ? psel_dec : '0;
      penable_q <= (state_d == S_ACCESS);
    end
  end

  assign bus.Hreadyout = hready;
  assign bus.Hresp     = hresp;
  assign bus.Hrdata    = hrdata;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pselx     = psel_q;
  assign bus.Penable   = penable_q;

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// Directed bench for ahb_apb_bridge_gen2 with an expected-transfer queue:
// each accepted AHB transfer pushes the APB transfer it should produce,
// popped and compared when the APB access completes.
module tb_ahb_apb_bridge_gen2;
  logic Hclk;
  logic Hresetn;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [2:0]  sel;
  } exp_t;

  exp_t sb[$];

  ahb_apb_bridge_gen2_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus();

  ahb_apb_bridge_gen2 dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                            input logic [2:0] sel);
    exp_t e;
    bus.Haddr  = a;
    bus.Htrans = 2'b10;
    bus.Hwrite = wr;
    e.addr = a; e.wr = wr; e.wd = wd; e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                            input logic [2:0] sel);
    @(posedge Hclk); #1;
    bus.Pready = 1'b0;
    drive_addr(a, wr, wd, sel);
    @(negedge Hclk);
    chk("addr_hready", 32'(bus.Hreadyout), 32'd1);
    chk("addr_hresp", 32'(bus.Hresp), 32'd0);
    chk("addr_psel", 32'(bus.Pselx), 32'd0);
    chk("addr_penable", 32'(bus.Penable), 32'd0);
  endtask

  task automatic data_phase(input logic [31:0] rd, input int nwait, input logic err,
                            input logic nxt, input logic [31:0] n_addr, input logic n_wr,
                            input logic [31:0] n_wd, input logic [2:0] n_sel);
    exp_t e;
    int   lows;
    e = sb[0];
    @(posedge Hclk); #1;
    bus.Htrans = 2'b00; bus.Hwdata = e.wd;
    bus.Pready = 1'b0; bus.Pslverr = 1'b0; bus.Prdata = rd;
    @(negedge Hclk);
    chk("latch_hready", 32'(bus.Hreadyout), 32'd0);
    chk("latch_psel", 32'(bus.Pselx), 32'd0);
    lows = bus.Hreadyout ? 0 : 1;
    @(posedge Hclk); #1;
    bus.Hwdata = ~e.wd;
    @(negedge Hclk);
    chk("setup_psel", 32'(bus.Pselx), 32'(e.sel));
    chk("setup_penable", 32'(bus.Penable), 32'd0);
    chk("setup_paddr", bus.Paddr, e.addr);
    chk("setup_pwrite", 32'(bus.Pwrite), 32'(e.wr));
    if (e.wr) chk("setup_pwdata", bus.Pwdata, e.wd);
    lows += bus.Hreadyout ? 0 : 1;
    for (int i = 0; i < nwait; i++) begin
      @(posedge Hclk); #1;
      @(negedge Hclk);
      chk("wait_penable", 32'(bus.Penable), 32'd1);
      chk("wait_psel", 32'(bus.Pselx), 32'(e.sel));
      chk("wait_hrdata", bus.Hrdata, 32'd0);
      lows += bus.Hreadyout ? 0 : 1;
    end
    @(posedge Hclk); #1;
    bus.Pready = 1'b1; bus.Pslverr = err; bus.Prdata = rd;
    if (nxt) drive_addr(n_addr, n_wr, n_wd, n_sel);
    @(negedge Hclk);
    e = sb.pop_front();
    chk("done_paddr", bus.Paddr, e.addr);
    chk("done_psel", 32'(bus.Pselx), 32'(e.sel));
    chk("done_pwrite", 32'(bus.Pwrite), 32'(e.wr));
    chk("done_penable", 32'(bus.Penable), 32'd1);
    chk("done_hready", 32'(bus.Hreadyout), 32'(!err));
    chk("done_hresp", 32'(bus.Hresp), 32'(err));
    chk("done_hrdata", bus.Hrdata, (e.wr || err) ? 32'd0 : rd);
    if (e.wr) chk("done_pwdata", bus.Pwdata, e.wd);
    if (!err) chk("wait_states", 32'(lows), 32'(2 + nwait));
    if (err) begin
      @(posedge Hclk); #1;
      bus.Pready = 1'b0; bus.Pslverr = 1'b0;
      @(negedge Hclk);
      chk("err2_hresp", 32'(bus.Hresp), 32'd1);
      chk("err2_hready", 32'(bus.Hreadyout), 32'd1);
      chk("err2_penable", 32'(bus.Penable), 32'd0);
      chk("err2_psel", 32'(bus.Pselx), 32'd0);
    end
  endtask

  task automatic out_of_map(input logic [31:0] a);
    @(posedge Hclk); #1;
    bus.Haddr = a; bus.Htrans = 2'b10; bus.Hwrite = 1'b1;
    @(negedge Hclk);
    chk("oor_t0_hready", 32'(bus.Hreadyout), 32'd1);
    @(posedge Hclk); #1;
    bus.Htrans = 2'b00;
    @(negedge Hclk);
    chk("oor_t1_hresp", 32'(bus.Hresp), 32'd1);
    chk("oor_t1_hready", 32'(bus.Hreadyout), 32'd0);
    chk("oor_t1_psel", 32'(bus.Pselx), 32'd0);
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("oor_t2_hresp", 32'(bus.Hresp), 32'd1);
    chk("oor_t2_hready", 32'(bus.Hreadyout), 32'd1);
    chk("oor_t2_psel", 32'(bus.Pselx), 32'd0);
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("oor_t3_hresp", 32'(bus.Hresp), 32'd0);
    chk("oor_t3_hready", 32'(bus.Hreadyout), 32'd1);
  endtask

  task automatic ignored(input logic [1:0] ht, input logic hri);
    @(posedge Hclk); #1;
    bus.Haddr = 32'h8000_0000; bus.Htrans = ht; bus.Hreadyin = hri;
    @(negedge Hclk);
    chk("ign_t0_hready", 32'(bus.Hreadyout), 32'd1);
    @(posedge Hclk); #1;
    bus.Htrans = 2'b00; bus.Hreadyin = 1'b1;
    @(negedge Hclk);
    chk("ign_t1_hready", 32'(bus.Hreadyout), 32'd1);
    chk("ign_t1_hresp", 32'(bus.Hresp), 32'd0);
    chk("ign_t1_psel", 32'(bus.Pselx), 32'd0);
  endtask

  initial begin
    bus.Haddr = '0; bus.Htrans = 2'b00; bus.Hwrite = 1'b0; bus.Hwdata = '0;
    bus.Hreadyin = 1'b1; bus.Prdata = '0; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
    Hresetn = 1'b0;
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_hready", 32'(bus.Hreadyout), 32'd1);
    chk("rst_hresp", 32'(bus.Hresp), 32'd0);
    chk("rst_hrdata", bus.Hrdata, 32'd0);
    chk("rst_psel", 32'(bus.Pselx), 32'd0);
    chk("rst_penable", 32'(bus.Penable), 32'd0);
    chk("rst_pwrite", 32'(bus.Pwrite), 32'd0);
    chk("rst_paddr", bus.Paddr, 32'd0);
    chk("rst_pwdata", bus.Pwdata, 32'd0);
    @(posedge Hclk); #1;
    Hresetn = 1'b1;

    addr_phase(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3'b001);
    data_phase(32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);

    addr_phase(32'h8400_0004, 1'b0, 32'h0, 3'b010);
    data_phase(32'h1234_5678, 3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);

    out_of_map(32'h8C00_0000);
    out_of_map(32'h7FFF_FFFC);

    addr_phase(32'h8BFF_FFFC, 1'b0, 32'h0, 3'b100);
    data_phase(32'h0F0F_0F0F, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);

    addr_phase(32'h8800_0000, 1'b1, 32'h5555_AAAA, 3'b100);
    data_phase(32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);

    ignored(2'b00, 1'b1);
    ignored(2'b01, 1'b1);
    ignored(2'b10, 1'b0);

    addr_phase(32'h8000_0000, 1'b1, 32'hA5A5_5A5A, 3'b001);
    data_phase(32'h0, 0, 1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0, 3'b001);
    data_phase(32'hCAFE_F00D, 1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);

    addr_phase(32'h8000_0008, 1'b0, 32'h0, 3'b001);
    @(posedge Hclk); #1;
    bus.Htrans = 2'b00;
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("rstmid_penable_before", 32'(bus.Penable), 32'd1);
    #2 Hresetn = 1'b0;
    #1;
    chk("rstmid_psel", 32'(bus.Pselx), 32'd0);
    chk("rstmid_penable", 32'(bus.Penable), 32'd0);
    chk("rstmid_hready", 32'(bus.Hreadyout), 32'd1);
    chk("rstmid_hresp", 32'(bus.Hresp), 32'd0);
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    sb.delete();

`ifdef BRIDGE_TIMEOUT_EN
    addr_phase(32'h8400_0100, 1'b0, 32'h0, 3'b010);
    @(posedge Hclk); #1;
    bus.Htrans = 2'b00;
    @(negedge Hclk);
    chk("to_latch_hready", 32'(bus.Hreadyout), 32'd0);
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("to_setup_psel", 32'(bus.Pselx), 32'd2);
    for (int i = 0; i < 16; i++) begin
      @(posedge Hclk); #1;
      @(negedge Hclk);
      chk("to_access_penable", 32'(bus.Penable), 32'd1);
      chk("to_access_hready", 32'(bus.Hreadyout), 32'd0);
    end
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("to_err1_psel", 32'(bus.Pselx), 32'd0);
    chk("to_err1_penable", 32'(bus.Penable), 32'd0);
    chk("to_err1_hresp", 32'(bus.Hresp), 32'd1);
    chk("to_err1_hready", 32'(bus.Hreadyout), 32'd0);
    @(posedge Hclk); #1;
    @(negedge Hclk);
    chk("to_err2_hresp", 32'(bus.Hresp), 32'd1);
    chk("to_err2_hready", 32'(bus.Hreadyout), 32'd1);
    void'(sb.pop_front());
`else
    addr_phase(32'h8400_0100, 1'b0, 32'h0, 3'b010);
    data_phase(32'h0BAD_CAFE, 100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
